bus_arbiter_ctrl: RTL and testbench
===================================

Name: bus_arbiter_ctrl

Overview:
- Shares the single external memory bus (AS_N / WR_N / ACK_N, address and data) between the pixel read machine and the write machine of the image-sharpening extension.
- Arbitrates between the two with round-robin priority and drives the bus handshake for the winner.
- Returns completion (and read data) to the requester, enforces a bus-turnaround cycle and an ACK timeout.
- Supports single-step operation through step_en for monitor-driven debugging.

Parameters:
- TIMEOUT, 16, cycles in a grant state waiting for ACK_N low before abort; 0 disables the timeout; legal range 0..255.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- step_mode  in  1  1 = a new grant may start only on a step_en cycle.
- step_en  in  1  single-step strobe, one cycle wide.
- rd_req  in  1  read machine request; held high until rd_done.
- rd_addr  in  AW  read address; stable while rd_req is high.
- rd_done  out  1  one-cycle pulse: read transaction finished.
- rd_data  out  DW  data captured from DI on read ACK; held until the next read.
- wr_req  in  1  write machine request; held high until wr_done.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_done  out  1  one-cycle pulse: write transaction finished.
- AS_N  out  1  bus address strobe, active low.
- WR_N  out  1  bus write enable, active low.
- AO  out  AW  bus address.
- DO  out  DW  bus write data.
- DI  in  DW  bus read data; valid when ACK_N is low.
- ACK_N  in  1  bus acknowledge, active low.
- bus_err  out  1  one-cycle pulse: transaction aborted on timeout.
- busy  out  1  1 in any state other than IDLE.
- state_out  out  2  current state encoding, for the monitor.

Behaviour:
- All outputs are registered.
- Reset values: AS_N=1, WR_N=1, AO=0, DO=0, rd_data=0, rd_done=0, wr_done=0, bus_err=0, busy=0, state_out=IDLE. last_grant=WR, so a read wins the first tie.
- State encoding: IDLE=00, GNT_RD=01, GNT_WR=10, RELEASE=11.
- IDLE:
  - A start is eligible when any request is pending and (step_mode=0 or step_en=1) in the same cycle.
  - One requester pending: that requester wins.
  - Both pending: the requester opposite last_grant wins; last_grant updates to the winner.
  - Next cycle: AO is the winner's address. AS_N=0. WR_N=0 for a write, 1 for a read. DO=wr_data for a write, otherwise unchanged. Latency from req sampled to AS_N low is 1 cycle.
  - step_en pulses with no pending request are ignored and not remembered.
- GNT_RD / GNT_WR:
  - AO, DO, AS_N and WR_N are held stable.
  - The timeout counter increments each cycle ACK_N=1.
  - First edge with ACK_N=0: go to RELEASE. On that transition AS_N=1, WR_N=1, and the matching done pulses for 1 cycle. GNT_RD also loads rd_data<=DI.
  - Timeout: with TIMEOUT>0, if ACK_N is still 1 on the TIMEOUT-th cycle in the grant state, go to RELEASE. On that transition AS_N=1, WR_N=1, bus_err=1 for one cycle, the matching done=1 for one cycle, and rd_data is unchanged.
  - If ACK_N and the timeout coincide, ACK wins: no bus_err.
  - A requester dropping req mid-grant is ignored; the transaction completes normally.
- RELEASE:
  - Lasts exactly 1 cycle; bus idle (AS_N=1).
  - Requests are not sampled, which prevents a double grant on a req that has not yet dropped.
  - Then go to IDLE; the timeout counter clears.
- Requester rule: drop req in the cycle after done. A req still high in IDLE is treated as a new request.
- Minimum transaction with immediate ACK: IDLE→GNT (1)→RELEASE (1)→IDLE, so back-to-back grants are 3 cycles apart.
- reset mid-transaction: next edge forces all reset values, with AS_N=1 immediately. No done or bus_err pulse is generated.
- The timeout counter is 8 bits and saturates. It never wraps in a way that re-triggers bus_err.

Test Plan:
- Single read, ACK_N low 3 cycles after AS_N falls, DI=0xA5A5_0001: rd_req at cycle 2 → AS_N=0 and WR_N=1 from cycle 3 with AO=rd_addr; rd_done pulse at cycle 6 with rd_data=0xA5A5_0001; AS_N=1 at cycle 6; busy=0 from cycle 7.
- Single write, addr=0x10, data=0xDEAD_BEEF, ACK_N held low: AS_N=0, WR_N=0, AO=0x10, DO=0xDEAD_BEEF for 1 cycle; wr_done 1 cycle; then RELEASE and IDLE.
- Simultaneous rd_req and wr_req, repeated 4 times after reset, requesters re-requesting immediately: grant order RD, WR, RD, WR; no two grants closer than 3 cycles.
- Timeout, TIMEOUT=16, ACK_N held 1: AS_N low exactly 16 cycles; then bus_err and wr_done pulse together; rd_data unchanged; IDLE 2 cycles later.
- Step mode, step_mode=1, wr_req high, step_en low for 10 cycles: AS_N stays 1. step_en pulses once → exactly one transaction. A second step_en pulse with no request → no bus activity.
- Reset asserted while in GNT_WR: next edge AS_N=1, WR_N=1, state_out=00, no wr_done or bus_err; after reset release a pending tie grants RD first.

Source files
------------

// File: rtl/bus_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_ctrl
//  Description : Shares one external memory bus between the pixel read
//                machine and the write machine. Round-robin arbitration,
//                registered AS_N/WR_N handshake, one-cycle bus turnaround,
//                ACK timeout with bus_err, and monitor-driven single-step.
//
//  Ports
//    clk, reset        : rising-edge clock, synchronous active-high reset
//    step_mode/step_en : when step_mode=1 a grant starts only on step_en
//    rd_req/rd_addr    : read request (held until rd_done) and address
//    rd_done/rd_data   : read completion pulse and captured DI
//    wr_req/wr_addr/   : write request (held until wr_done), address, data
//    wr_data
//    wr_done           : write completion pulse
//    AS_N/WR_N/AO/DO   : bus strobe, write enable, address, write data
//    DI/ACK_N          : bus read data and acknowledge (active low)
//    bus_err           : pulse on timeout abort
//    busy/state_out    : status for the monitor
//
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_mode,
    input  logic          step_en,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_done,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_done,
    output logic          AS_N,
    output logic          WR_N,
    output logic [AW-1:0] AO,
    output logic [DW-1:0] DO,
    input  logic [DW-1:0] DI,
    input  logic          ACK_N,
    output logic          bus_err,
    output logic          busy,
    output logic [1:0]    state_out
);

    localparam logic [1:0] c_st_idle    = 2'b00;
    localparam logic [1:0] c_st_gnt_rd  = 2'b01;
    localparam logic [1:0] c_st_gnt_wr  = 2'b10;
    localparam logic [1:0] c_st_release = 2'b11;

    // The counter holds the number of completed grant cycles, so the abort
    // fires while the TIMEOUT-th grant cycle is being sampled.
    localparam bit         c_tmo_en   = (TIMEOUT > 0);
    localparam logic [7:0] c_tmo_last = 8'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [1:0]    r_state,     w_state_nxt;
    logic [7:0]    r_tcnt,      w_tcnt_nxt;
    logic          r_last_wr,   w_last_wr_nxt;
    logic          r_as_n,      w_as_n_nxt;
    logic          r_wr_n,      w_wr_n_nxt;
    logic [AW-1:0] r_ao,        w_ao_nxt;
    logic [DW-1:0] r_do,        w_do_nxt;
    logic [DW-1:0] r_rd_data,   w_rd_data_nxt;
    logic          r_rd_done,   w_rd_done_nxt;
    logic          r_wr_done,   w_wr_done_nxt;
    logic          r_bus_err,   w_bus_err_nxt;
    logic          r_busy,      w_busy_nxt;

    logic w_start;
    logic w_pick_wr;
    logic w_tmo_hit;

    assign w_start   = (rd_req | wr_req) & (~step_mode | step_en);
    // A write wins when alone, or on a tie when the previous grant was a read.
    assign w_pick_wr = wr_req & (~rd_req | ~r_last_wr);
    assign w_tmo_hit = c_tmo_en & (r_tcnt == c_tmo_last);

    always_comb begin
        w_state_nxt   = r_state;
        w_tcnt_nxt    = r_tcnt;
        w_last_wr_nxt = r_last_wr;
        w_as_n_nxt    = r_as_n;
        w_wr_n_nxt    = r_wr_n;
        w_ao_nxt      = r_ao;
        w_do_nxt      = r_do;
        w_rd_data_nxt = r_rd_data;
        w_rd_done_nxt = 1'b0;
        w_wr_done_nxt = 1'b0;
        w_bus_err_nxt = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_tcnt_nxt = 8'd0;
                if (w_start) begin
                    w_last_wr_nxt = w_pick_wr;
                    w_as_n_nxt    = 1'b0;
                    if (w_pick_wr) begin
                        w_state_nxt = c_st_gnt_wr;
                        w_wr_n_nxt  = 1'b0;
                        w_ao_nxt    = wr_addr;
                        w_do_nxt    = wr_data;
                    end else begin
                        w_state_nxt = c_st_gnt_rd;
                        w_wr_n_nxt  = 1'b1;
                        w_ao_nxt    = rd_addr;
                    end
                end
            end

            c_st_gnt_rd, c_st_gnt_wr: begin
                // ACK is tested first so it wins over a coincident timeout.
                if (!ACK_N) begin
                    w_state_nxt = c_st_release;
                    w_as_n_nxt  = 1'b1;
                    w_wr_n_nxt  = 1'b1;
                    if (r_state == c_st_gnt_rd) begin
                        w_rd_done_nxt = 1'b1;
                        w_rd_data_nxt = DI;
                    end else begin
                        w_wr_done_nxt = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt   = c_st_release;
                    w_as_n_nxt    = 1'b1;
                    w_wr_n_nxt    = 1'b1;
                    w_bus_err_nxt = 1'b1;
                    w_rd_done_nxt = (r_state == c_st_gnt_rd);
                    w_wr_done_nxt = (r_state == c_st_gnt_wr);
                end else if (r_tcnt != 8'hFF) begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end

            c_st_release: begin
                // Turnaround cycle: requests are deliberately not looked at.
                w_state_nxt = c_st_idle;
                w_tcnt_nxt  = 8'd0;
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_tcnt_nxt  = 8'd0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_tcnt    <= 8'd0;
            r_last_wr <= 1'b1;
            r_as_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ao      <= '0;
            r_do      <= '0;
            r_rd_data <= '0;
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;
            r_bus_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_last_wr <= w_last_wr_nxt;
            r_as_n    <= w_as_n_nxt;
            r_wr_n    <= w_wr_n_nxt;
            r_ao      <= w_ao_nxt;
            r_do      <= w_do_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_rd_done <= w_rd_done_nxt;
            r_wr_done <= w_wr_done_nxt;
            r_bus_err <= w_bus_err_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign AS_N      = r_as_n;
    assign WR_N      = r_wr_n;
    assign AO        = r_ao;
    assign DO        = r_do;
    assign rd_data   = r_rd_data;
    assign rd_done   = r_rd_done;
    assign wr_done   = r_wr_done;
    assign bus_err   = r_bus_err;
    assign busy      = r_busy;
    assign state_out = r_state;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter_ctrl
//  Description : Randomized self-checking bench for bus_arbiter_ctrl. A
//                transaction-timeline reference model predicts every output
//                cycle by cycle from the arbitration and handshake rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_ctrl;

    localparam int c_TIMEOUT = 16;
    localparam int c_AW      = 32;
    localparam int c_DW      = 32;
    localparam int c_PHASE_CYCLES = 700;

    logic            clk = 1'b0;
    logic            reset;
    logic            step_mode, step_en;
    logic            rd_req, wr_req;
    logic [c_AW-1:0] rd_addr, wr_addr;
    logic [c_DW-1:0] wr_data, DI;
    logic            ACK_N;
    logic            rd_done, wr_done, AS_N, WR_N, bus_err, busy;
    logic [c_DW-1:0] rd_data, DO;
    logic [c_AW-1:0] AO;
    logic [1:0]      state_out;

    always #5 clk = ~clk;

    bus_arbiter_ctrl #(
        .TIMEOUT (c_TIMEOUT),
        .AW      (c_AW),
        .DW      (c_DW)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .step_mode (step_mode),
        .step_en   (step_en),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .AS_N      (AS_N),
        .WR_N      (WR_N),
        .AO        (AO),
        .DO        (DO),
        .DI        (DI),
        .ACK_N     (ACK_N),
        .bus_err   (bus_err),
        .busy      (busy),
        .state_out (state_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the current/last transaction as a time window.
    bit              m_act     = 1'b0;
    bit              m_wr      = 1'b0;
    bit              m_to      = 1'b0;
    bit              m_last_wr = 1'b1;
    int              m_start   = -100;
    int              m_len     = 0;
    int              m_k       = 0;
    int              m_free    = 0;
    logic [c_AW-1:0] e_ao      = '0;
    logic [c_DW-1:0] e_do      = '0;
    logic [c_DW-1:0] e_rd      = '0;

    // Requester and phase bookkeeping
    bit rd_pend = 1'b0;
    bit wr_pend = 1'b0;
    bit force_tie = 1'b0;
    int rd_done_at = -10;
    int wr_done_at = -10;
    int n_resets = 0;
    int phase = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit g;
        bit r;
        g = m_act && (cyc >= m_start + 1) && (cyc <= m_start + m_len);
        r = m_act && (cyc == m_start + m_len + 1);
        check_eq("AS_N",    64'(AS_N),      g ? 64'd0 : 64'd1);
        check_eq("WR_N",    64'(WR_N),      (g && m_wr) ? 64'd0 : 64'd1);
        check_eq("state",   64'(state_out), g ? (m_wr ? 64'd2 : 64'd1) : (r ? 64'd3 : 64'd0));
        check_eq("busy",    64'(busy),      64'(g || r));
        check_eq("rd_done", 64'(rd_done),   64'(r && !m_wr));
        check_eq("wr_done", 64'(wr_done),   64'(r && m_wr));
        check_eq("bus_err", 64'(bus_err),   64'(r && m_to));
        check_eq("AO",      64'(AO),        64'(e_ao));
        check_eq("DO",      64'(DO),        64'(e_do));
        check_eq("rd_data", 64'(rd_data),   64'(e_rd));
    endtask

    // ACK delay (grant cycle index at which ACK_N is low) per phase.
    function automatic int pick_k(input int ph);
        int v;
        case (ph)
            2:       v = 1;
            3:       v = int'($urandom_range(2, 8));
            4:       v = int'($urandom_range(c_TIMEOUT - 1, c_TIMEOUT + 3));
            default: v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(c_TIMEOUT - 1, c_TIMEOUT + 4))
                                                     : int'($urandom_range(1, 4));
        endcase
        return v;
    endfunction

    task automatic drive_cycle();
        int new_pct;
        int rereq_pct;
        bit in_gnt;
        new_pct   = (phase == 2) ? 100 : 30;
        rereq_pct = (phase == 2) ? 100 : 30;
        reset = 1'b0;

        if (force_tie) begin
            rd_pend = 1'b1; rd_addr = $urandom;
            wr_pend = 1'b1; wr_addr = $urandom; wr_data = $urandom;
            force_tie = 1'b0;
        end

        // Requesters drop (or immediately re-request) the cycle after done.
        if (cyc == rd_done_at + 1) begin
            rd_pend = (int'($urandom_range(0, 99)) < rereq_pct);
            if (rd_pend) rd_addr = $urandom;
        end
        if (cyc == wr_done_at + 1) begin
            wr_pend = (int'($urandom_range(0, 99)) < rereq_pct);
            if (wr_pend) begin wr_addr = $urandom; wr_data = $urandom; end
        end
        if (!rd_pend && int'($urandom_range(0, 99)) < new_pct) begin
            rd_pend = 1'b1; rd_addr = $urandom;
        end
        if (!wr_pend && int'($urandom_range(0, 99)) < new_pct) begin
            wr_pend = 1'b1; wr_addr = $urandom; wr_data = $urandom;
        end
        rd_req = rd_pend;
        wr_req = wr_pend;

        step_mode = (phase == 1);
        step_en   = ($urandom_range(0, 99) < 15);
        DI        = $urandom;

        in_gnt = m_act && (cyc >= m_start + 1) && (cyc <= m_start + m_len);
        if (in_gnt) ACK_N = !((cyc - m_start) == m_k);
        else        ACK_N = 1'($urandom_range(0, 1));

        if (phase == 3 && n_resets < 6 && in_gnt && m_wr && (cyc >= m_start + 2)
            && $urandom_range(0, 2) == 0) begin
            reset = 1'b1;
            n_resets++;
        end
    endtask

    task automatic model_step();
        bit w;
        if (reset) begin
            m_act = 1'b0; m_last_wr = 1'b1;
            e_ao = '0; e_do = '0; e_rd = '0;
            m_free = cyc + 1;
            rd_done_at = -10; wr_done_at = -10;
            force_tie = 1'b1;
            return;
        end
        if (m_act && !m_wr && !m_to && cyc == m_start + m_len) e_rd = DI;
        if (cyc >= m_free && (rd_req || wr_req) && (!step_mode || step_en)) begin
            w = wr_req && (!rd_req || !m_last_wr);
            m_last_wr = w;
            m_wr = w;
            m_act = 1'b1;
            m_start = cyc;
            m_k = pick_k(phase);
            if (c_TIMEOUT > 0 && m_k > c_TIMEOUT) begin m_len = c_TIMEOUT; m_to = 1'b1; end
            else begin m_len = m_k; m_to = 1'b0; end
            m_free = cyc + m_len + 2;
            if (w) begin
                e_ao = wr_addr; e_do = wr_data; wr_done_at = cyc + m_len + 1;
            end else begin
                e_ao = rd_addr; rd_done_at = cyc + m_len + 1;
            end
        end
    endtask

    initial begin
        reset = 1'b1; step_mode = 1'b0; step_en = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; ACK_N = 1'b1;
        rd_addr = '0; wr_addr = '0; wr_data = '0; DI = '0;
        cyc = 0;
        @(posedge clk); #1 cyc++;
        @(posedge clk); #1 cyc++;
        m_free = cyc;
        check_outputs();

        for (int ph = 0; ph < 5; ph++) begin
            phase = ph;
            for (int n = 0; n < c_PHASE_CYCLES; n++) begin
                drive_cycle();
                model_step();
                @(posedge clk); #1 cyc++;
                check_outputs();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
